// File: rtl/mem_arbiter.sv
// Two-port arbiter that shares one slow line-wide memory between the D-cache and I-cache.
// Memory strobes, address and write line are registered at grant time and held until mem_ready.
//
//   state  | meaning
//   IDLE   | no transaction outstanding; next requester (or tie winner) is granted at the edge
//   BUSY_D | D-cache transaction in flight; ready_D follows mem_ready
//   BUSY_I | I-cache transaction in flight; ready_I follows mem_ready
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int RR     = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              read_D,
    input  logic              write_D,
    input  logic [ADDR_W-1:0] addr_D,
    input  logic [DATA_W-1:0] wdata_D,
    output logic [DATA_W-1:0] rdata_D,
    output logic              ready_D,

    input  logic              read_I,
    input  logic              write_I,
    input  logic [ADDR_W-1:0] addr_I,
    input  logic [DATA_W-1:0] wdata_I,
    output logic [DATA_W-1:0] rdata_I,
    output logic              ready_I,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_D = 2'd1,
        BUSY_I = 2'd2
    } state_t;

    localparam bit ROUND_ROBIN = (RR != 0);

    state_t              state_q, state_d;
    logic                last_i_q, last_i_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic                req_d;
    logic                req_i;
    logic                grant_d;

    assign req_d = read_D | write_D;
    assign req_i = read_I | write_I;

    // D wins a tie under fixed priority, or under round-robin when I was served last.
    assign grant_d = req_d & (~req_i | ~ROUND_ROBIN | last_i_q);

    always_comb begin
        state_d     = state_q;
        last_i_d    = last_i_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                if (grant_d) begin
                    state_d     = BUSY_D;
                    mem_write_d = write_D;
                    mem_read_d  = read_D & ~write_D;
                    mem_addr_d  = addr_D;
                    mem_wdata_d = wdata_D;
                end else if (req_i) begin
                    state_d     = BUSY_I;
                    mem_write_d = write_I;
                    mem_read_d  = read_I & ~write_I;
                    mem_addr_d  = addr_I;
                    mem_wdata_d = wdata_I;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    state_d     = IDLE;
                    last_i_d    = 1'b0;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
            end
            BUSY_I: begin
                if (mem_ready) begin
                    state_d     = IDLE;
                    last_i_d    = 1'b1;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_i_q    <= 1'b1;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_i_q    <= last_i_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Only the strobes are steered; both caches see the memory line directly.
    assign ready_D = ~rst & (state_q == BUSY_D) & mem_ready;
    assign ready_I = ~rst & (state_q == BUSY_I) & mem_ready;
    assign rdata_D = mem_rdata;
    assign rdata_I = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin and a fixed-priority instance share cache stimulus,
// each with its own latency-4 memory model and transaction-level reference model.
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          read_D, write_D, read_I, write_I;
    logic [AW-1:0] addr_D, addr_I;
    logic [DW-1:0] wdata_D, wdata_I;

    logic [DW-1:0] mem_rdata [2];
    logic          mem_ready [2];
    logic [DW-1:0] rdata_D [2];
    logic [DW-1:0] rdata_I [2];
    logic          ready_D [2];
    logic          ready_I [2];
    logic          mem_read [2];
    logic          mem_write [2];
    logic [AW-1:0] mem_addr [2];
    logic [DW-1:0] mem_wdata [2];

    // index 0: round-robin, index 1: fixed priority
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR(1)) u_rr (
        .clk(clk), .rst(rst),
        .read_D(read_D), .write_D(write_D), .addr_D(addr_D), .wdata_D(wdata_D),
        .rdata_D(rdata_D[0]), .ready_D(ready_D[0]),
        .read_I(read_I), .write_I(write_I), .addr_I(addr_I), .wdata_I(wdata_I),
        .rdata_I(rdata_I[0]), .ready_I(ready_I[0]),
        .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .mem_ready(mem_ready[0])
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR(0)) u_fp (
        .clk(clk), .rst(rst),
        .read_D(read_D), .write_D(write_D), .addr_D(addr_D), .wdata_D(wdata_D),
        .rdata_D(rdata_D[1]), .ready_D(ready_D[1]),
        .read_I(read_I), .write_I(write_I), .addr_I(addr_I), .wdata_I(wdata_I),
        .rdata_I(rdata_I[1]), .ready_I(ready_I[1]),
        .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .mem_ready(mem_ready[1])
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // transaction-level reference: which port owns memory, what was issued, who went last
    int            m_busy [2];   // 0 none, 1 D, 2 I
    logic          m_last_i [2];
    logic          m_re [2];
    logic          m_we [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_wdata [2];

    int            mcnt [2];
    bit            rand_mem;

    int            step_idx;
    int            rd_first [2];
    int            rdy_d_first [2];
    int            rdy_i_first [2];
    int            rdy_d_cnt [2];
    int            rdy_i_cnt [2];

    string         nm [2] = '{"rr", "fp"};

    task automatic chk_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic clr_trace();
        step_idx = 0;
        for (int i = 0; i < 2; i++) begin
            rd_first[i]    = -1;
            rdy_d_first[i] = -1;
            rdy_i_first[i] = -1;
            rdy_d_cnt[i]   = 0;
            rdy_i_cnt[i]   = 0;
        end
    endtask

    task automatic mem_drive();
        for (int i = 0; i < 2; i++) begin
            mem_ready[i] = 1'b0;
            if (mcnt[i] > 0) begin
                mcnt[i]--;
                if (mcnt[i] == 0) begin
                    mem_ready[i] = 1'b1;
                    mem_rdata[i] = rand_line();
                end
            end else if (mem_read[i] || mem_write[i]) begin
                mcnt[i] = 4;
            end else if (rand_mem && $urandom_range(0, 15) == 0) begin
                mem_ready[i] = 1'b1;
                mem_rdata[i] = rand_line();
            end
        end
    endtask

    task automatic check_outputs();
        logic exp_rd, exp_ri;
        for (int i = 0; i < 2; i++) begin
            exp_rd = !rst && m_busy[i] == 1 && mem_ready[i];
            exp_ri = !rst && m_busy[i] == 2 && mem_ready[i];
            chk_eq({nm[i], " mem_read"},  DW'(mem_read[i]),  DW'(m_re[i]));
            chk_eq({nm[i], " mem_write"}, DW'(mem_write[i]), DW'(m_we[i]));
            chk_eq({nm[i], " ready_D"},   DW'(ready_D[i]),   DW'(exp_rd));
            chk_eq({nm[i], " ready_I"},   DW'(ready_I[i]),   DW'(exp_ri));
            if (m_busy[i] != 0) begin
                chk_eq({nm[i], " mem_addr"},  DW'(mem_addr[i]), DW'(m_addr[i]));
                chk_eq({nm[i], " mem_wdata"}, mem_wdata[i],     m_wdata[i]);
            end
            if (exp_rd) chk_eq({nm[i], " rdata_D"}, rdata_D[i], mem_rdata[i]);
            if (exp_ri) chk_eq({nm[i], " rdata_I"}, rdata_I[i], mem_rdata[i]);
            if ((mem_read[i] || mem_write[i]) && rd_first[i] < 0) rd_first[i] = step_idx;
            if (ready_D[i]) begin
                rdy_d_cnt[i]++;
                if (rdy_d_first[i] < 0) rdy_d_first[i] = step_idx;
            end
            if (ready_I[i]) begin
                rdy_i_cnt[i]++;
                if (rdy_i_first[i] < 0) rdy_i_first[i] = step_idx;
            end
        end
    endtask

    task automatic model_update();
        logic rq_d, rq_i, pick_d;
        rq_d = read_D | write_D;
        rq_i = read_I | write_I;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_busy[i] = 0; m_last_i[i] = 1'b1; m_re[i] = 1'b0; m_we[i] = 1'b0;
                m_addr[i] = '0; m_wdata[i] = '0;
            end else if (m_busy[i] != 0) begin
                if (mem_ready[i]) begin
                    m_last_i[i] = (m_busy[i] == 2);
                    m_busy[i] = 0; m_re[i] = 1'b0; m_we[i] = 1'b0;
                end
            end else if (rq_d || rq_i) begin
                pick_d = rq_d && (!rq_i || i == 1 || m_last_i[i]);
                m_busy[i]  = pick_d ? 1 : 2;
                m_we[i]    = pick_d ? write_D : write_I;
                m_re[i]    = pick_d ? (read_D & ~write_D) : (read_I & ~write_I);
                m_addr[i]  = pick_d ? addr_D : addr_I;
                m_wdata[i] = pick_d ? wdata_D : wdata_I;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        mem_drive();
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
        step_idx++;
    endtask

    task automatic clear_inputs();
        read_D = 0; write_D = 0; read_I = 0; write_I = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic rand_port(output logic rd, output logic wr,
                             output logic [AW-1:0] a, output logic [DW-1:0] d);
        rd = 1'($urandom_range(0, 1));
        wr = ($urandom_range(0, 2) == 0);
        a  = AW'($urandom());
        d  = rand_line();
    endtask

    logic [AW-1:0] a_keep;

    initial begin
        rst = 1'b1;
        clear_inputs();
        addr_D = '0; addr_I = '0; wdata_D = '0; wdata_I = '0;
        rand_mem = 0;
        for (int i = 0; i < 2; i++) begin
            mem_ready[i] = 1'b0; mem_rdata[i] = '0; mcnt[i] = 0;
            m_busy[i] = 0; m_last_i[i] = 1'b1; m_re[i] = 1'b0; m_we[i] = 1'b0;
            m_addr[i] = '0; m_wdata[i] = '0;
        end
        clr_trace();
        repeat (2) @(posedge clk);
        #1;

        // reset state
        step();
        for (int i = 0; i < 2; i++) begin
            chk_eq({nm[i], " reset mem_addr"},  DW'(mem_addr[i]), '0);
            chk_eq({nm[i], " reset mem_wdata"}, mem_wdata[i],     '0);
        end
        rst = 1'b0;

        // single D read
        clr_trace();
        read_D = 1; addr_D = 28'h0000010; wdata_D = rand_line();
        for (int s = 0; s < 8; s++) begin
            step();
            if (s == 5) read_D = 0;
        end
        for (int i = 0; i < 2; i++) begin
            chk_eq({nm[i], " single strobe cycle"}, DW'(rd_first[i]),    DW'(1));
            chk_eq({nm[i], " single ready_D cycle"}, DW'(rdy_d_first[i]), DW'(5));
            chk_eq({nm[i], " single ready_D count"}, DW'(rdy_d_cnt[i]),   DW'(1));
            chk_eq({nm[i], " single ready_I count"}, DW'(rdy_i_cnt[i]),   DW'(0));
        end

        // both ports held continuously from reset
        do_reset();
        clr_trace();
        read_D = 1; read_I = 1; addr_D = AW'($urandom()); addr_I = AW'($urandom());
        for (int s = 0; s < 18; s++) step();
        chk_eq("rr tie first D",      DW'(rdy_d_first[0]), DW'(5));
        chk_eq("rr tie then I",       DW'(rdy_i_first[0]), DW'(11));
        chk_eq("rr tie D count",      DW'(rdy_d_cnt[0]),   DW'(2));
        chk_eq("rr tie I count",      DW'(rdy_i_cnt[0]),   DW'(1));
        chk_eq("fp tie first D",      DW'(rdy_d_first[1]), DW'(5));
        chk_eq("fp tie D count",      DW'(rdy_d_cnt[1]),   DW'(3));
        chk_eq("fp tie I starved",    DW'(rdy_i_cnt[1]),   DW'(0));
        clear_inputs();
        step();
        step();

        // I-cache write with a fixed pattern
        clr_trace();
        write_I = 1; addr_I = 28'h0000020; wdata_I = {16{8'hA5}};
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            chk_eq({nm[i], " wr mem_write"}, DW'(mem_write[i]), DW'(1));
            chk_eq({nm[i], " wr mem_read"},  DW'(mem_read[i]),  DW'(0));
            chk_eq({nm[i], " wr mem_wdata"}, mem_wdata[i],      {16{8'hA5}});
            chk_eq({nm[i], " wr mem_addr"},  DW'(mem_addr[i]),  DW'(28'h0000020));
        end
        for (int s = 2; s < 8; s++) begin
            step();
            if (s == 5) write_I = 0;
        end
        for (int i = 0; i < 2; i++) begin
            chk_eq({nm[i], " wr ready_I count"}, DW'(rdy_i_cnt[i]),   DW'(1));
            chk_eq({nm[i], " wr ready_I cycle"}, DW'(rdy_i_first[i]), DW'(5));
        end

        // reset in the second BUSY_D cycle abandons the transaction
        clr_trace();
        read_D = 1; addr_D = AW'($urandom());
        step();
        step();
        rst = 1'b1; read_D = 0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 2; i++)
            chk_eq({nm[i], " abort mem_read"}, DW'(mem_read[i]), DW'(0));
        for (int s = 3; s < 8; s++) step();
        for (int i = 0; i < 2; i++) begin
            chk_eq({nm[i], " abort ready_D count"}, DW'(rdy_d_cnt[i]), DW'(0));
            chk_eq({nm[i], " abort ready_I count"}, DW'(rdy_i_cnt[i]), DW'(0));
        end

        // read+write together, other port's address moving mid-transaction
        clr_trace();
        a_keep = AW'($urandom());
        read_D = 1; write_D = 1; addr_D = a_keep; read_I = 1; addr_I = AW'($urandom());
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            chk_eq({nm[i], " rw mem_write"}, DW'(mem_write[i]), DW'(1));
            chk_eq({nm[i], " rw mem_read"},  DW'(mem_read[i]),  DW'(0));
        end
        addr_I = ~addr_I;
        step();
        step();
        for (int i = 0; i < 2; i++)
            chk_eq({nm[i], " rw mem_addr held"}, DW'(mem_addr[i]), DW'(a_keep));
        step();
        step();
        clear_inputs();
        step();
        step();

        // randomized traffic, spurious mem_ready and occasional resets
        rand_mem = 1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) rand_port(read_D, write_D, addr_D, wdata_D);
            if ($urandom_range(0, 3) == 0) rand_port(read_I, write_I, addr_I, wdata_I);
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        rand_mem = 0;
        clear_inputs();
        repeat (8) step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
